// File: rtl/pe_accumulator.sv
// Sums a programmable number of signed PE chunks, then requantises the total
// by arithmetic right shift with saturation onto a valid/ready output.
module pe_accumulator #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int CNT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [CNT_WIDTH-1:0]   num_chunks,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [ACC_WIDTH-1:0]   out_raw,
  output logic                   out_sat,
  output logic                   busy
);

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ACC_WIDTH-1:0]  raw;
    logic                  sat;
  } res_t;

  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]         len_q, len_d;
  res_t                         res_q, res_d;
  logic                         ov_q, ov_d;

  logic signed [ACC_WIDTH-1:0]  in_sext, sum, shr;
  logic [CNT_WIDTH-1:0]         eff_len;
  logic                         last, accept, done;

  assign in_ready = !ov_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign in_sext  = {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign eff_len  = (num_chunks == '0) ? CNT_WIDTH'(1) : num_chunks;
  assign sum      = (state_q == IDLE) ? in_sext : acc_q + in_sext;
  assign last     = (state_q == IDLE) ? (eff_len == CNT_WIDTH'(1))
                                      : (cnt_q == len_q - CNT_WIDTH'(1));
  assign done     = accept && last;

  // Shifts past the accumulator width collapse to the sign fill.
  always_comb begin
    if (32'(shift) >= 32'(ACC_WIDTH)) shr = {ACC_WIDTH{sum[ACC_WIDTH-1]}};
    else                              shr = sum >>> shift;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    res_d   = res_q;
    ov_d    = ov_q;

    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      if (state_q == IDLE) len_d = eff_len;
      if (last) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = sum;
        cnt_d   = (state_q == IDLE) ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);
      end
    end

    // A completion overrides the pop so back-to-back results have no bubble.
    if (done) begin
      ov_d     = 1'b1;
      res_d.raw = sum;
      if (shr > MAX_V) begin
        res_d.data = MAX_V[DATA_WIDTH-1:0];
        res_d.sat  = 1'b1;
      end else if (shr < MIN_V) begin
        res_d.data = MIN_V[DATA_WIDTH-1:0];
        res_d.sat  = 1'b1;
      end else begin
        res_d.data = shr[DATA_WIDTH-1:0];
        res_d.sat  = 1'b0;
      end
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = res_q.data;
  assign out_raw   = res_q.raw;
  assign out_sat   = res_q.sat;
  assign busy      = (state_q == ACCUM);

endmodule
